// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned NUM_DIGITS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic [3:0]  disp_val,
   output logic [3:0]  an_n,
   output logic        frame_tick
);

   localparam int unsigned CntW = $clog2(REFRESH_DIV);
   localparam int unsigned IdxW = $clog2(NUM_DIGITS);
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      StBlank = 2'b00,
      StScan  = 2'b01,
      StPend  = 2'b10
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [15:0]     active_q, active_d;
   logic [15:0]     shadow_q, shadow_d;
   logic [3:0]      disp_q, disp_d;
   logic [3:0]      an_q, an_d;
   logic            frame_tick_q, frame_tick_d;

   logic tick;
   logic boundary;
   logic handshake;
   logic blank_digit;

   assign load_ready = (state_q != StPend);
   assign handshake  = load_valid & load_ready;
   assign tick       = (state_q != StBlank) && (cnt_q == CntMax);
   assign boundary   = tick && (idx_q == IdxLast);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      active_d = active_q;
      shadow_d = shadow_q;

      unique case (state_q)
         StBlank: begin
            cnt_d = '0;
            idx_d = '0;
            if (handshake) begin
               active_d = load_data;
               state_d  = StScan;
            end
         end
         StScan: begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
            if (tick) idx_d = idx_q + IdxW'(1);
            // A load landing on a boundary tick waits for the next boundary.
            if (handshake) begin
               shadow_d = load_data;
               state_d  = StPend;
            end
         end
         StPend: begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
            if (tick) idx_d = idx_q + IdxW'(1);
            if (boundary) begin
               active_d = shadow_q;
               state_d  = StScan;
            end
         end
         default: begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Outputs are registered from next-state values so the new digit shows one cycle after tick.
   always_comb begin
      blank_digit = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      blank_digit = (idx_d != '0) && ((active_d >> {idx_d, 2'b00}) == 16'h0000);
`else
      blank_digit = 1'b0;
`endif
      disp_d       = active_d[{idx_d, 2'b00} +: 4];
      an_d         = ((state_d == StBlank) || blank_digit) ? 4'b1111 : ~(4'b0001 << idx_d);
      frame_tick_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StBlank;
         cnt_q        <= '0;
         idx_q        <= '0;
         active_q     <= 16'h0000;
         shadow_q     <= 16'h0000;
         disp_q       <= 4'h0;
         an_q         <= 4'b1111;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         disp_q       <= disp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign disp_val   = disp_q;
   assign an_n       = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed scenarios plus random loads/resets against a timeline model.
module tb_ssd_scan_ctrl;

   localparam int Div   = 4;
   localparam int Frame = 4 * Div;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic [3:0]  disp_val;
   logic [3:0]  an_n;
   logic        frame_tick;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;
   int ft_count;

   // Model: time since scanning began, committed value, and any queued value.
   bit          m_scan;
   bit          m_pend;
   int          m_t;
   logic [15:0] m_active;
   logic [15:0] m_shadow;

   ssd_scan_ctrl #(
      .REFRESH_DIV(Div),
      .NUM_DIGITS (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_ready(load_ready),
      .disp_val  (disp_val),
      .an_n      (an_n),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_digit();
      return (m_t / Div) % 4;
   endfunction

   function automatic logic [3:0] exp_disp();
      if (!m_scan) return 4'h0;
      return 4'((m_active >> (4 * m_digit())) & 16'h000f);
   endfunction

   function automatic logic [3:0] exp_an();
      int d;
      if (!m_scan) return 4'b1111;
      d = m_digit();
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (d > 0 && (m_active >> (4 * d)) == 16'h0000) return 4'b1111;
`endif
      return ~(4'b0001 << d);
   endfunction

   task automatic model_step();
      bit was_pend;
      if (rst) begin
         m_scan = 0; m_pend = 0; m_t = 0; m_active = '0; m_shadow = '0;
      end else if (!m_scan) begin
         if (load_valid) begin
            m_active = load_data; m_scan = 1; m_t = 0;
         end
      end else begin
         was_pend = m_pend;
         if (load_valid && !m_pend) begin
            m_shadow = load_data; m_pend = 1;
         end
         m_t++;
         if (m_t % Frame == 0 && was_pend) begin
            m_active = m_shadow; m_pend = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("an_n", 16'(an_n), 16'(exp_an()));
         chk("disp_val", 16'(disp_val), 16'(exp_disp()));
         chk("load_ready", 16'(load_ready), 16'(!m_pend));
         chk("frame_tick", 16'(frame_tick), 16'(m_scan && m_t > 0 && m_t % Frame == 0));
      end
   end

   task automatic step(input logic v, input logic [15:0] d, input logic r);
      load_valid = v;
      load_data  = d;
      rst        = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      load_valid = 1'b0;
      rst        = 1'b0;
   endtask

   task automatic run_to(input int target);
      int guard = 0;
      while (m_t != target && guard < 200) begin
         step(1'b0, 16'h0, 1'b0);
         guard++;
      end
      chk("run_to_reached", 16'(m_t == target), 16'd1);
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = 16'h0;
      m_scan = 0; m_pend = 0; m_t = 0; m_active = '0; m_shadow = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_an", 16'(an_n), 16'hf);
      chk("rst_disp", 16'(disp_val), 16'h0);
      chk("rst_ready", 16'(load_ready), 16'd1);
      chk("rst_ft", 16'(frame_tick), 16'd0);

      // Idle after reset: stays blank, never ticks a frame.
      ft_count = 0;
      repeat (50) begin
         step(1'b0, 16'h0, 1'b0);
         if (frame_tick) ft_count++;
      end
      chk("idle_ft_count", 16'(ft_count), 16'd0);
      chk("idle_an", 16'(an_n), 16'hf);

      // First load from blank lights digit 0 immediately.
      step(1'b1, 16'h12af, 1'b0);
      chk("l0_an", 16'(an_n), 16'he);
      chk("l0_disp", 16'(disp_val), 16'hf);
      repeat (4) step(1'b0, 16'h0, 1'b0);
      chk("l1_an", 16'(an_n), 16'hd);
      chk("l1_disp", 16'(disp_val), 16'ha);
      repeat (4) step(1'b0, 16'h0, 1'b0);
      chk("l2_an", 16'(an_n), 16'hb);
      chk("l2_disp", 16'(disp_val), 16'h2);
      repeat (4) step(1'b0, 16'h0, 1'b0);
      chk("l3_an", 16'(an_n), 16'h7);
      chk("l3_disp", 16'(disp_val), 16'h1);
      chk("l3_ft", 16'(frame_tick), 16'd0);
      repeat (4) step(1'b0, 16'h0, 1'b0);
      chk("wrap_ft", 16'(frame_tick), 16'd1);
      chk("wrap_disp", 16'(disp_val), 16'hf);

      // Mid-frame load queues; a second offer while pending is dropped.
      run_to(21);
      step(1'b1, 16'h0000, 1'b0);
      chk("pend_ready", 16'(load_ready), 16'd0);
      step(1'b1, 16'hbeef, 1'b0);
      run_to(28);
      chk("old_frame_disp", 16'(disp_val), 16'h1);
      chk("old_frame_an", 16'(an_n), 16'h7);
      run_to(32);
      chk("commit_disp", 16'(disp_val), 16'h0);
      chk("commit_ready", 16'(load_ready), 16'd1);
      run_to(36);
      chk("zero_d1_disp", 16'(disp_val), 16'h0);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      chk("zero_d1_an", 16'(an_n), 16'hf);
`else
      chk("zero_d1_an", 16'(an_n), 16'hd);
`endif

      // Leading-zero pattern committed at the next boundary.
      step(1'b1, 16'h0050, 1'b0);
      run_to(52);
      chk("p50_d1_disp", 16'(disp_val), 16'h5);
      chk("p50_d1_an", 16'(an_n), 16'hd);
      run_to(56);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      chk("p50_d2_an", 16'(an_n), 16'hf);
`else
      chk("p50_d2_an", 16'(an_n), 16'hb);
`endif
      run_to(64);
      chk("p50_d0_an", 16'(an_n), 16'he);
      chk("p50_d0_disp", 16'(disp_val), 16'h0);

      // Reset while pending at digit 2: queued value must never appear.
      step(1'b1, 16'h3c3c, 1'b0);
      run_to(73);
      step(1'b0, 16'h0, 1'b1);
      chk("rstp_an", 16'(an_n), 16'hf);
      chk("rstp_ready", 16'(load_ready), 16'd1);
      chk("rstp_disp", 16'(disp_val), 16'h0);
      repeat (20) step(1'b0, 16'h0, 1'b0);
      chk("rstp_still_blank", 16'(an_n), 16'hf);

      // Random loads and occasional resets, checked every cycle by the compare process.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 299) == 0));
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
